load_store_unit: RTL

Sits between the datapath (ALU address, rt store data, control decode) and the data memory. Converts byte, halfword and word load/store requests into aligned 32-bit word accesses on the data memory port. Sub-word stores use read-modify-write; loads are extracted and sign- or zero-extended. A valid/ready handshake stalls the core while an access is in flight.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the core datapath and the load/store unit.
// The core drives the master side and the LSU implements the slave side.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit onto a 32-bit word-wide data memory.
// Define LSU_SUBWORD_EN for byte/halfword accesses (read-modify-write stores).
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    load_store_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic                  o_mem_write_en,
    output logic [31:0]           o_mem_write_data,
    input  logic [31:0]           i_mem_read_data
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
`ifdef LSU_SUBWORD_EN
    localparam logic [2:0] S_RMW_READ = 3'd2;
`endif

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_bad;
    logic [2:0]            w_accept_state;
    logic [31:0]           w_load;
    logic                  w_mem_active;
    logic [ADDR_WIDTH-1:0] w_aligned;

    assign w_aligned = {r_addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_SUBWORD_EN
    logic [1:0]  r_size;
    logic        r_signed;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merge;

    always_comb begin
        w_bad = 1'b0;
        unique case (bus.req_size)
            2'b00:   w_bad = 1'b0;
            2'b01:   w_bad = bus.req_addr[0];
            2'b10:   w_bad = |bus.req_addr[1:0];
            default: w_bad = 1'b1;
        endcase
    end

    // Lane select uses the registered address; memory data is the pre-write word.
    always_comb begin
        w_byte = i_mem_read_data[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? i_mem_read_data[31:16]
                           : i_mem_read_data[15:0];
        w_load = i_mem_read_data;
        if (r_size == 2'b00) begin
            w_load = {{24{r_signed & w_byte[7]}}, w_byte};
        end else if (r_size == 2'b01) begin
            w_load = {{16{r_signed & w_half[15]}}, w_half};
        end
        w_merge = i_mem_read_data;
        if (r_size == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    assign w_mem_active = (r_state == S_LOAD) ||
                          (r_state == S_RMW_READ) ||
                          (r_state == S_WRITE);
`else
    logic w_unused;

    always_comb begin
        w_bad = (bus.req_size != 2'b10) || (bus.req_addr[1:0] != 2'b00);
    end

    assign w_load       = i_mem_read_data;
    assign w_unused     = ^{r_addr[1:0], bus.req_signed};
    assign w_mem_active = (r_state == S_LOAD) || (r_state == S_WRITE);
`endif

    always_comb begin
        w_accept_state = S_WRITE;
        if (w_bad) begin
            w_accept_state = S_RESP;
        end else if (!bus.req_write) begin
            w_accept_state = S_LOAD;
`ifdef LSU_SUBWORD_EN
        end else if (bus.req_size != 2'b10) begin
            w_accept_state = S_RMW_READ;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
`ifdef LSU_SUBWORD_EN
            r_size   <= 2'b00;
            r_signed <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_rdata  <= '0;
                        r_err    <= w_bad;
`ifdef LSU_SUBWORD_EN
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
`endif
                        r_state  <= w_accept_state;
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load;
                    r_state <= S_RESP;
                end
`ifdef LSU_SUBWORD_EN
                S_RMW_READ: begin
                    r_wdata <= w_merge;
                    r_state <= S_WRITE;
                end
`endif
                S_WRITE: r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
    assign bus.resp_err   = (r_state == S_RESP) && r_err;

    // Write enable is cut by reset so an interrupted WRITE never lands.
    assign o_mem_address    = w_mem_active ? w_aligned : '0;
    assign o_mem_write_en   = (r_state == S_WRITE) && !i_reset;
    assign o_mem_write_data = (r_state == S_WRITE) ? r_wdata : 32'd0;

endmodule
